mpu6050_responder: RTL

Synthesizable I2C target that emulates the MPU-6050 register interface seen by the on-chip I2C master. It replaces the constant sensor stubs in simulation and serves as an FPGA loopback target for bring-up without the physical sensor. Sensor samples come from parallel inputs, which a testbench or a pattern generator drives. The block answers address writes, register-pointer writes, single-byte writes and burst reads on an open-drain SDA.

---
 rtl/mpu6050_pkg.sv | 33 +++
 rtl/i2c_line_sync.sv | 46 ++++
 rtl/mpu6050_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu6050_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu6050_pkg
//  Purpose  : Shared types and register map for the MPU-6050 I2C responder.
//  Revision : 1.0 - initial release
// ============================================================================
package mpu6050_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK    = 3'd2,
        ST_REG    = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_e;

    localparam logic [7:0] REG_CONFIG       = 8'h1A;
    localparam logic [7:0] REG_GYRO_CONFIG  = 8'h1B;
    localparam logic [7:0] REG_ACCEL_CONFIG = 8'h1C;
    localparam logic [7:0] REG_SAMPLE_FIRST = 8'h3B;
    localparam logic [7:0] REG_SAMPLE_LAST  = 8'h48;
    localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I     = 8'h75;

    localparam logic [7:0] PWR_MGMT_1_RST   = 8'h40;
    localparam int         SLEEP_BIT        = 6;
    localparam int         SAMPLE_WORDS     = 7;
    localparam int         SHADOW_BYTES     = 2 * SAMPLE_WORDS;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_line_sync
//  Purpose  : Synchronises raw SCL/SDA and detects SCL edges, START and STOP.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Idle bus level is high, so flops reset to 1 to avoid spurious edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
    assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
    assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
    assign sda_o      = sda_sync_q[1];

endmodule
`default_nettype wire

// File: rtl/mpu6050_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mpu6050_responder
//  Purpose  : I2C target emulating the MPU-6050 register interface.
//  Revision : 1.0 - initial release
// ============================================================================
module mpu6050_responder
    import mpu6050_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter logic [7:0] WHO_AM_I = 8'h68
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [15:0] accel_x_i,
    input  logic [15:0] accel_y_i,
    input  logic [15:0] accel_z_i,
    input  logic [15:0] temp_i,
    input  logic [15:0] gyro_x_i,
    input  logic [15:0] gyro_y_i,
    input  logic [15:0] gyro_z_i,
    output logic        sleep_o,
    output logic        busy_o
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    i2c_line_sync u_line_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop),
        .sda_o      (w_sda)
    );

    state_e      state_q,     state_d;
    state_e      ret_q,       ret_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  tx_q,        tx_d;
    logic [7:0]  ptr_q,       ptr_d;
    logic        ack_inc_q,   ack_inc_d;
    logic        nack_q,      nack_d;
    logic        sda_oe_q,    sda_oe_d;
    logic        busy_q,      busy_d;
    logic [7:0]  config_q,    config_d;
    logic [7:0]  gyro_cfg_q,  gyro_cfg_d;
    logic [7:0]  accel_cfg_q, accel_cfg_d;
    logic [7:0]  pwr_q,       pwr_d;
    logic [7:0]  shadow_q [SHADOW_BYTES];
    logic [7:0]  shadow_d [SHADOW_BYTES];

    logic [15:0] w_samples [SAMPLE_WORDS];
    logic [7:0]  w_rd_data;
    logic [7:0]  w_wr_byte;
    logic [3:0]  w_shadow_idx;

    assign w_samples[0] = accel_x_i;
    assign w_samples[1] = accel_y_i;
    assign w_samples[2] = accel_z_i;
    assign w_samples[3] = temp_i;
    assign w_samples[4] = gyro_x_i;
    assign w_samples[5] = gyro_y_i;
    assign w_samples[6] = gyro_z_i;

    assign w_wr_byte    = {shift_q[6:0], w_sda};
    // 0x3B..0x48 maps to 0..13 using only the low nibble (mod-16 arithmetic).
    assign w_shadow_idx = ptr_q[3:0] - 4'hB;

    always_comb begin
        w_rd_data = 8'h00;
        if (ptr_q >= REG_SAMPLE_FIRST && ptr_q <= REG_SAMPLE_LAST) begin
            w_rd_data = pwr_q[SLEEP_BIT] ? 8'h00 : shadow_q[w_shadow_idx];
        end else begin
            case (ptr_q)
                REG_CONFIG:       w_rd_data = config_q;
                REG_GYRO_CONFIG:  w_rd_data = gyro_cfg_q;
                REG_ACCEL_CONFIG: w_rd_data = accel_cfg_q;
                REG_PWR_MGMT_1:   w_rd_data = pwr_q;
                REG_WHO_AM_I:     w_rd_data = WHO_AM_I;
                default:          w_rd_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        ack_inc_d   = ack_inc_q;
        nack_d      = nack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        config_d    = config_q;
        gyro_cfg_d  = gyro_cfg_q;
        accel_cfg_d = accel_cfg_q;
        pwr_d       = pwr_q;
        shadow_d    = shadow_q;

        if (w_stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else if (w_start) begin
            state_d   = ST_ADDR;
            busy_d    = 1'b1;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (w_scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = w_wr_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit happens only once the last data bit is in.
                        if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
                            case (ptr_q)
                                REG_CONFIG:       config_d    = w_wr_byte;
                                REG_GYRO_CONFIG:  gyro_cfg_d  = w_wr_byte;
                                REG_ACCEL_CONFIG: accel_cfg_d = w_wr_byte;
                                REG_PWR_MGMT_1:   pwr_d       = w_wr_byte;
                                default:          ;
                            endcase
                        end
                    end else if (w_scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = ST_ACK;
                        sda_oe_d  = 1'b1;
                        ack_inc_d = (state_q == ST_WDATA);
                        ret_d     = ST_WDATA;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] != DEV_ADDR) begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                            end else if (shift_q[0]) begin
                                ret_d = ST_RDATA;
                                for (int k = 0; k < SAMPLE_WORDS; k++) begin
                                    shadow_d[2*k]   = w_samples[k][15:8];
                                    shadow_d[2*k+1] = w_samples[k][7:0];
                                end
                            end else begin
                                ret_d = ST_REG;
                            end
                        end else if (state_q == ST_REG) begin
                            ptr_d = shift_q;
                        end
                    end
                end
                ST_ACK: begin
                    if (w_scl_rise && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd9;
                    end else if (w_scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ret_q;
                        if (ack_inc_q) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                        if (ret_q == ST_RDATA) begin
                            tx_d     = w_rd_data;
                            sda_oe_d = ~w_rd_data[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        if (bit_cnt_q == 4'd8) begin
                            nack_d    = w_sda;
                            bit_cnt_d = 4'd9;
                            if (!w_sda) begin
                                ptr_d = ptr_q + 8'd1;
                            end
                        end else if (bit_cnt_q < 4'd8) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (w_scl_fall) begin
                        if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                        end else if (bit_cnt_q == 4'd9) begin
                            if (nack_q) begin
                                state_d = ST_IGNORE;
                            end else begin
                                bit_cnt_d = 4'd0;
                                tx_d      = w_rd_data;
                                sda_oe_d  = ~w_rd_data[7];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            ack_inc_q   <= 1'b0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            config_q    <= 8'h00;
            gyro_cfg_q  <= 8'h00;
            accel_cfg_q <= 8'h00;
            pwr_q       <= PWR_MGMT_1_RST;
            for (int i = 0; i < SHADOW_BYTES; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            ack_inc_q   <= ack_inc_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            config_q    <= config_d;
            gyro_cfg_q  <= gyro_cfg_d;
            accel_cfg_q <= accel_cfg_d;
            pwr_q       <= pwr_d;
            for (int i = 0; i < SHADOW_BYTES; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign sda_oe_o = sda_oe_q;
    assign sleep_o  = pwr_q[SLEEP_BIT];
    assign busy_o   = busy_q;

endmodule
`default_nettype wire
